// File: rtl/md_hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes, FSM states,
// pipeline stall and divider start constants.
package md_hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_WAIT,
        ST_DIV_BUSY,
        ST_DONE
    } md_state_e;

    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/md_hilo_regs.sv
// HI/LO architectural register pair with independent write enables.
module md_hilo_regs (
    input  logic        clk,
    input  logic        resetn,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hi_wdata,
    input  logic [31:0] lo_wdata,
    output logic [31:0] hi_rdata,
    output logic [31:0] lo_rdata
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_rdata <= '0;
            lo_rdata <= '0;
        end else begin
            if (hi_we) hi_rdata <= hi_wdata;
            if (lo_we) lo_rdata <= lo_wdata;
        end
    end

endmodule

// File: rtl/md_hilo_ctrl.sv
// EX-stage sequencer for multiply/divide: issues to external units, stalls the
// pipe while in flight, commits HI/LO once, and aborts on flush.
module md_hilo_ctrl
    import md_hilo_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        ex_hold,
    input  logic        flush,
    output logic        stallreq,
    output logic [31:0] hi_rdata,
    output logic [31:0] lo_rdata,
    output logic [31:0] mf_data,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready
);

    md_state_e        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      opa_q, opb_q;
    logic             sgn_q;
    logic             latch;
    logic             hi_we, lo_we;
    logic [31:0]      hi_wd, lo_wd;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            opa_q <= '0;
            opb_q <= '0;
            sgn_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (latch) begin
                opa_q <= src_a;
                opb_q <= src_b;
                sgn_q <= is_signed_op(op);
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        stallreq  = NO_STOP;
        div_start = DIV_STOP;
        div_annul = 1'b0;
        latch     = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        hi_wd     = '0;
        lo_wd     = '0;
        case (state)
            ST_IDLE: begin
                if (op_valid && !flush) begin
                    if (is_mul(op)) begin
                        stallreq = STOP;
                        latch    = 1'b1;
                        cnt_n    = CNT_W'(MUL_LAT);
                        state_n  = ST_MUL_WAIT;
                    end else if (is_div(op)) begin
                        stallreq = STOP;
                        latch    = 1'b1;
                        state_n  = ST_DIV_BUSY;
                    end else if (!ex_hold && op == OP_MTHI) begin
                        hi_we = 1'b1;
                        hi_wd = src_a;
                    end else if (!ex_hold && op == OP_MTLO) begin
                        lo_we = 1'b1;
                        lo_wd = src_a;
                    end
                end
            end
            ST_MUL_WAIT: begin
                stallreq = STOP;
                cnt_n    = cnt - CNT_W'(1);
                if (flush) begin
                    state_n = ST_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    hi_we   = 1'b1;
                    lo_we   = 1'b1;
                    hi_wd   = mul_result[63:32];
                    lo_wd   = mul_result[31:0];
                    state_n = ST_DONE;
                end
            end
            ST_DIV_BUSY: begin
                stallreq = STOP;
                // Abort wins over a same-cycle result; the divider is told to drop it.
                if (flush) begin
                    div_annul = resetn;
                    state_n   = ST_IDLE;
                end else begin
                    div_start = DIV_START;
                    if (div_ready) begin
                        hi_we   = 1'b1;
                        lo_we   = 1'b1;
                        hi_wd   = div_result[63:32];
                        lo_wd   = div_result[31:0];
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Instruction is still in EX until the external hold releases; don't re-issue.
                if (flush || !ex_hold) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    md_hilo_regs u_regs (
        .clk      (clk),
        .resetn   (resetn),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hi_wdata (hi_wd),
        .lo_wdata (lo_wd),
        .hi_rdata (hi_rdata),
        .lo_rdata (lo_rdata)
    );

    assign mf_data    = (op == OP_MFLO) ? lo_rdata : hi_rdata;
    assign mul_signed = sgn_q;
    assign mul_ina    = opa_q;
    assign mul_inb    = opb_q;
    assign div_signed = sgn_q;
    assign div_opa    = opa_q;
    assign div_opb    = opb_q;

endmodule
